// File: rtl/padder_pkg.sv
// padder_pkg: shared constants for the 576-bit SHA3 padder.
// PADDER_LEGACY_KECCAK_EN selects the original Keccak pad byte 0x01 instead of 0x06.
package padder_pkg;
    localparam int RATE_BYTES = 72;
    localparam int RATE_BITS  = 8 * RATE_BYTES;
    localparam int BYTE_NUM_W = 10;
    localparam logic [BYTE_NUM_W-1:0] FULL_N = BYTE_NUM_W'(RATE_BYTES);
`ifdef PADDER_LEGACY_KECCAK_EN
    localparam logic [7:0] PAD_FIRST_BYTE = 8'h01;
`else
    localparam logic [7:0] PAD_FIRST_BYTE = 8'h06;
`endif
    localparam logic [7:0] PAD_LAST_BYTE = 8'h80;
    localparam logic [RATE_BITS-1:0] PAD_BLOCK = {PAD_FIRST_BYTE, {(RATE_BITS-16){1'b0}}, PAD_LAST_BYTE};
endpackage

// File: rtl/padder_pad_gen.sv
// padder_pad_gen: combinational multi-rate padding of a final block holding byte_num valid bytes.
module padder_pad_gen
    import padder_pkg::*;
(
    input  logic [RATE_BITS-1:0]  in,
    input  logic [BYTE_NUM_W-1:0] byte_num,
    output logic [RATE_BITS-1:0]  out
);
    logic [BYTE_NUM_W-1:0] w_n;
    assign w_n = (byte_num > FULL_N) ? FULL_N : byte_num;
    for (genvar i = 0; i < RATE_BYTES; i++) begin : g_byte
        logic [7:0] w_sel;
        assign w_sel = (BYTE_NUM_W'(i) < w_n)  ? in[RATE_BITS-1-8*i -: 8] :
                       (BYTE_NUM_W'(i) == w_n) ? PAD_FIRST_BYTE : 8'h00;
        if (i == RATE_BYTES - 1) begin : g_last
            // a full block carries no padding; the trailing bit goes in the extra block
            assign out[7:0] = w_sel | ((w_n != FULL_N) ? PAD_LAST_BYTE : 8'h00);
        end else begin : g_mid
            assign out[RATE_BITS-1-8*i -: 8] = w_sel;
        end
    end
endmodule

// File: rtl/padder_576.sv
// padder_576: SHA3-512 rate padder with a one-entry output buffer and extra pad-block generation.
// Define PADDER_LEGACY_KECCAK_EN for original Keccak padding (first pad byte 0x01).
module padder_576
    import padder_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [RATE_BITS-1:0]  in,
    input  logic                  in_ready,
    input  logic                  is_last,
    input  logic [BYTE_NUM_W-1:0] byte_num,
    output logic                  buffer_full,
    output logic [RATE_BITS-1:0]  out,
    output logic                  out_ready,
    input  logic                  f_ack
);
    logic [RATE_BITS-1:0] r_out;
    logic                 r_full;
    logic                 r_extra;
    logic [RATE_BITS-1:0] w_pad;

    padder_pad_gen u_pad (
        .in       (in),
        .byte_num (byte_num),
        .out      (w_pad)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out   <= '0;
            r_full  <= 1'b0;
            r_extra <= 1'b0;
        end else if (r_full) begin
            // input is held off while full; an ack either frees the buffer or swaps in the pad block
            if (f_ack) begin
                if (r_extra) r_out <= PAD_BLOCK;
                r_full  <= r_extra;
                r_extra <= 1'b0;
            end
        end else if (in_ready) begin
            r_out   <= is_last ? w_pad : in;
            r_full  <= 1'b1;
            r_extra <= is_last && (byte_num >= FULL_N);
        end
    end

    assign out         = r_out;
    assign out_ready   = r_full;
    assign buffer_full = r_full;
endmodule

// File: tb/tb_padder_576.sv
// tb_padder_576: directed self-checking bench for padder_576.
module tb_padder_576;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [575:0] in = '0;
    logic         in_ready = 1'b0;
    logic         is_last = 1'b0;
    logic [9:0]   byte_num = '0;
    logic         buffer_full;
    logic [575:0] out;
    logic         out_ready;
    logic         f_ack = 1'b0;

    int checks = 0;
    int errors = 0;

`ifdef PADDER_LEGACY_KECCAK_EN
    logic [7:0] pf = 8'h01;
`else
    logic [7:0] pf = 8'h06;
`endif
    logic [575:0] p, q, r, pad_blk;

    padder_576 dut (
        .clk         (clk),
        .reset       (reset),
        .in          (in),
        .in_ready    (in_ready),
        .is_last     (is_last),
        .byte_num    (byte_num),
        .buffer_full (buffer_full),
        .out         (out),
        .out_ready   (out_ready),
        .f_ack       (f_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [575:0] got, input logic [575:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [575:0] d, input logic last, input logic [9:0] n);
        in = d;
        is_last = last;
        byte_num = n;
        in_ready = 1'b1;
        step();
        in_ready = 1'b0;
    endtask

    task automatic ack();
        f_ack = 1'b1;
        step();
        f_ack = 1'b0;
    endtask

    initial begin
        p = {9{64'h90ABCDEF11111111}};
        q = {9{64'h0123456789ABCDEF}};
        r = {72{8'h5A}};
        pad_blk = {pf, 560'b0, 8'h80};
        step();
        step();
        check("rst_ready", out_ready, 0);
        check("rst_full", buffer_full, 0);
        check("rst_out", out, 0);
        reset = 1'b0;
        step();
        check("idle_ack_noeffect", out_ready, 0);

        send(p, 1'b1, 10'd64);
        check("n64_ready", out_ready, 1);
        check("n64_full", buffer_full, 1);
        check("n64_out", out, {{8{64'h90ABCDEF11111111}}, pf, 48'h0, 8'h80});
        ack();
        check("n64_ack_ready", out_ready, 0);
        check("n64_ack_keep", out, {{8{64'h90ABCDEF11111111}}, pf, 48'h0, 8'h80});

        send(p, 1'b1, 10'd0);
        check("n0_out", out, pad_blk);
        ack();

        send(p, 1'b1, 10'd71);
        check("n71_out", out, {{8{64'h90ABCDEF11111111}}, 56'h90ABCDEF111111, pf | 8'h80});
        ack();

        send(p, 1'b1, 10'd72);
        check("n72_out", out, p);
        check("n72_ready", out_ready, 1);
        ack();
        check("n72_extra_out", out, pad_blk);
        check("n72_extra_ready", out_ready, 1);
        ack();
        check("n72_done_ready", out_ready, 0);

        send(q, 1'b1, 10'd100);
        check("n100_out", out, q);
        ack();
        check("n100_extra_out", out, pad_blk);
        check("n100_extra_full", buffer_full, 1);
        ack();
        check("n100_done", buffer_full, 0);

        send(q, 1'b0, 10'd5);
        check("nonlast_out", out, q);
        in = r;
        in_ready = 1'b1;
        step();
        check("hold_out", out, q);
        check("hold_full", buffer_full, 1);
        f_ack = 1'b1;
        step();
        f_ack = 1'b0;
        check("ackin_ready", out_ready, 0);
        check("ackin_out", out, q);
        step();
        in_ready = 1'b0;
        check("held_accept_out", out, r);
        check("held_accept_ready", out_ready, 1);
        ack();

        send(p, 1'b1, 10'd72);
        check("pre_rst_full", buffer_full, 1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_ready", out_ready, 0);
        check("async_rst_out", out, 0);
        step();
        reset = 1'b0;
        step();
        ack();
        check("no_extra_ready", out_ready, 0);
        check("no_extra_out", out, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/padder_576.md
Name: padder_576

Overview:
- Keccak/SHA3 message padder for a 576-bit rate (72 bytes, SHA3-512 sponge), sitting between the message source and the Keccak-f permutation core.
- Takes one full-width block per handshake and passes non-final blocks through unchanged.
- Applies SHA3 multi-rate padding to the final block, generating an extra pad-only block when the final block is full.
- Holds each output block in a one-entry buffer until the core acknowledges it.

Parameters:
- RATE_BYTES, 72, block size in bytes; data width is 8*RATE_BYTES = 576.
- BYTE_NUM_W, 10, width of byte_num.

Ports:
- clk, input, 1, single clock; all state on rising edge.
- reset, input, 1, asynchronous active-high reset.
- in, input, 576, message block; byte 0 = in[575:568], byte 71 = in[7:0].
- in_ready, input, 1, block valid strobe.
- is_last, input, 1, marks the final block of the message; qualified by in_ready.
- byte_num, input, 10, count of valid bytes in the final block, 0..72; ignored when is_last=0.
- buffer_full, output, 1, output buffer occupied; identical to out_ready.
- out, output, 576, padded block, same byte order as in.
- out_ready, output, 1, out holds a valid block for the core.
- f_ack, input, 1, core has consumed out.

Behaviour:
- Reset: out=0, out_ready=0, buffer_full=0, pending-extra flag=0. Reset mid-operation discards the buffer and any pending extra block.
- Accept rule: a block is accepted at a rising edge when in_ready=1 and buffer_full=0 (registered value). Input is ignored while full; the source must hold it.
- Latency: out and out_ready become valid at the accept edge, one cycle after in_ready is presented.
- Non-last block (is_last=0): out = in verbatim.
- Last block, byte_num=n with n<72:
  - bytes 0..n-1 = in bytes.
  - byte n = 0x06.
  - bytes n+1..71 = 0x00.
  - byte 71 is ORed with 0x80; n=71 therefore gives byte 71 = 0x86.
  - Input bytes at positions >= n are discarded.
- Last block with n=72: out = in, and pending-extra is set.
- byte_num > 72 is treated as 72.
- f_ack while buffer_full:
  - With pending-extra set: the next edge loads the pad-only block (byte 0=0x06, bytes 1..70=0x00, byte 71=0x80), keeps buffer_full=1, and clears pending-extra.
  - Otherwise: buffer_full and out_ready clear at the next edge; out keeps its last value.
- f_ack while empty has no effect.
- f_ack and in_ready in the same cycle while full: only the ack is processed; the input is accepted on a later edge.
- After the final (or extra) block is acked, the next accepted block starts a new message; there is no done lockout.
- Only one block is ever buffered.

Optional Feature:
- Macro PADDER_LEGACY_KECCAK_EN.
- Defined: original Keccak pad10*1; the first pad byte is 0x01 instead of 0x06 (n=71 gives byte 71 = 0x81; the pad-only block starts with 0x01).
- Undefined (default): SHA3 domain byte 0x06.

Decomposition:
- Package padder_pkg: RATE_BYTES=72, RATE_BITS=576, PAD_FIRST_BYTE (0x06/0x01 per macro), PAD_LAST_BYTE=0x80.
- Sub-module padder_pad_gen: combinational; inputs in and byte_num, output the padded 576-bit block via per-byte select (keep / first-pad / zero) plus an OR of 0x80 into byte 71.
- Top padder_576 holds the buffer, the pending-extra flag and the handshake.

Test Plan:
- Reset, then in = 9 x 64'h90ABCDEF11111111, byte_num=64, is_last=1, one-cycle in_ready -> next edge out_ready=buffer_full=1; out = first 64 input bytes, then 06 00 00 00 00 00 00 80.
- byte_num=0, is_last=1 -> out = 06, 70 x 00, 80; byte_num=71 -> bytes 0..70 = input, byte 71 = 0x86.
- byte_num=72, is_last=1 -> first out = in unchanged; after f_ack, out = 06 00..00 80 with out_ready staying 1; second f_ack -> out_ready=0.
- Non-last block, then in_ready held while full -> out unchanged until f_ack; buffer_full drops the edge after f_ack; the held input is accepted on the following edge.
- Assert reset asynchronously between clock edges while full with pending-extra -> out_ready=0 and out=0 immediately; no extra block is produced after the next f_ack.
- With PADDER_LEGACY_KECCAK_EN, byte_num=64 -> byte 64 = 0x01, byte 71 = 0x80.
